// File: rtl/rc4_pkg.sv
// Shared types for the RC4 key-scheduling controller: FSM states, S-box depth and byte type.
package rc4_pkg;

    localparam int S_DEPTH = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        LATCH_I,
        RD_J,
        LATCH_J,
        WR_I,
        WR_J,
        DONE
    } state_e;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Combinational key-byte mux: picks byte idx_i of an MSB-first packed key.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int KIDX_W    = 2
) (
    input  logic [8*KEY_BYTES-1:0] key_i,
    input  logic [KIDX_W-1:0]      idx_i,
    output byte_t                  key_byte_o
);

    always_comb begin
        key_byte_o = key_i[8*KEY_BYTES-1 -: 8];
        for (int k = 1; k < KEY_BYTES; k++) begin
            if (idx_i == KIDX_W'(k)) key_byte_o = key_i[8*(KEY_BYTES-k)-1 -: 8];
        end
    end

endmodule

// File: rtl/rc4_ksa_controller.sv
// RC4 key-scheduling controller driving a single-port 256x8 S memory.
// Define RC4_INIT_PHASE_EN to include the S[i]=i initialisation pass; otherwise S is preloaded externally.
module rc4_ksa_controller
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_we,
    input  logic [7:0]             mem_rdata,
    output logic                   busy,
    output logic                   done
);

    localparam int    KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam byte_t I_LAST = byte_t'(S_DEPTH - 1);

    state_e            state_q;
    byte_t             i_q, j_q, si_q, sj_q;
    byte_t             addr_q, wdata_q;
    logic              we_q, busy_q, done_q;
    logic [KIDX_W-1:0] kidx_q, kidx_d;
    byte_t             i_d, j_d, key_byte;

    rc4_key_byte_sel #(
        .KEY_BYTES (KEY_BYTES),
        .KIDX_W    (KIDX_W)
    ) u_key_sel (
        .key_i      (key),
        .idx_i      (kidx_q),
        .key_byte_o (key_byte)
    );

    // Key index wraps alongside i so no modulo is ever computed.
    assign kidx_d = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
    assign i_d    = i_q + 8'd1;
    assign j_d    = j_q + mem_rdata + key_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        i_q     <= '0;
                        j_q     <= '0;
                        kidx_q  <= '0;
                        addr_q  <= '0;
                        wdata_q <= '0;
`ifdef RC4_INIT_PHASE_EN
                        we_q    <= 1'b1;
                        state_q <= INIT;
`else
                        state_q <= RD_I;
`endif
                    end
                end
                INIT: begin
                    if (i_q == I_LAST) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        kidx_q  <= '0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        state_q <= RD_I;
                    end else begin
                        i_q     <= i_d;
                        addr_q  <= i_d;
                        wdata_q <= i_d;
                    end
                end
                RD_I:    state_q <= LATCH_I;
                LATCH_I: begin
                    si_q    <= mem_rdata;
                    j_q     <= j_d;
                    addr_q  <= j_d;
                    state_q <= RD_J;
                end
                RD_J:    state_q <= LATCH_J;
                // Swap data is issued straight from the read bus to save a cycle.
                LATCH_J: begin
                    sj_q    <= mem_rdata;
                    addr_q  <= i_q;
                    wdata_q <= mem_rdata;
                    we_q    <= 1'b1;
                    state_q <= WR_I;
                end
                WR_I: begin
                    addr_q  <= j_q;
                    wdata_q <= si_q;
                    state_q <= WR_J;
                end
                WR_J: begin
                    we_q <= 1'b0;
                    if (i_q == I_LAST) begin
                        addr_q  <= '0;
                        wdata_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        i_q     <= i_d;
                        kidx_q  <= kidx_d;
                        addr_q  <= i_d;
                        state_q <= RD_I;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rc4_ksa_controller.sv
// Randomized bench for rc4_ksa_controller: three instances (KEY_BYTES 1/3/5) against a software RC4 KSA model.
module tb_rc4_ksa_controller;

    localparam int N = 3;
`ifdef RC4_INIT_PHASE_EN
    localparam int EXP_LAT = 1793;
    localparam int INIT_W  = 256;
`else
    localparam int EXP_LAT = 1537;
    localparam int INIT_W  = 0;
`endif
    localparam int LAT_MAX = 4000;

    logic        clk, rst_n, preload;
    logic        start     [N];
    logic [63:0] key       [N];
    logic [7:0]  mem_addr  [N];
    logic [7:0]  mem_wdata [N];
    logic [7:0]  mem_rdata [N];
    logic        mem_we    [N];
    logic        busy      [N];
    logic        done      [N];
    logic [7:0]  smem      [N][256];
    logic [7:0]  wa_q[$], wd_q[$];
    int          n_chk = 0, n_err = 0;

    function automatic int kb_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 5);
    endfunction

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int KB = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
        rc4_ksa_controller #(.KEY_BYTES(KB)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .key       (key[g][8*KB-1:0]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_we    (mem_we[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port S memory, one-cycle read latency.
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            mem_rdata[g] <= smem[g][mem_addr[g]];
            if (preload) begin
                for (int k = 0; k < 256; k++)
`ifdef RC4_INIT_PHASE_EN
                    smem[g][k] <= ~8'(k);
`else
                    smem[g][k] <= 8'(k);
`endif
            end else if (mem_we[g]) begin
                smem[g][mem_addr[g]] <= mem_wdata[g];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ksa_model(input logic [63:0] k, input int kb, output logic [7:0] s [256]);
        int j;
        logic [7:0] t, kbyte;
        for (int i = 0; i < 256; i++) s[i] = 8'(i);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kbyte = 8'(k >> (8 * (kb - 1 - (i % kb))));
            j = (j + int'(s[i]) + int'(kbyte)) % 256;
            t = s[i];
            s[i] = s[j];
            s[j] = t;
        end
    endtask

    task automatic pulse_preload();
        @(negedge clk) preload = 1'b1;
        @(negedge clk) preload = 1'b0;
    endtask

    task automatic run_sched(input string tag);
        int cyc;
        bit seen;
        logic [7:0] exp_s [256];
        int lat;
        wa_q.delete();
        wd_q.delete();
        pulse_preload();
        for (int g = 0; g < N; g++) start[g] = 1'b1;
        @(posedge clk);
        cyc  = 1;
        seen = 1'b0;
        @(negedge clk);
        for (int g = 0; g < N; g++) start[g] = 1'b0;
        chk({tag, "_busy_on"}, 32'(busy[1]), 32'd1);
        while (!seen && cyc < LAT_MAX) begin
            if (mem_we[1]) begin
                wa_q.push_back(mem_addr[1]);
                wd_q.push_back(mem_wdata[1]);
            end
            if (done[1]) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        lat = seen ? cyc : 0;
        chk({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
        chk({tag, "_busy_at_done"}, 32'(busy[1]), 32'd0);
        chk({tag, "_done_others"}, 32'({done[0], done[2]}), 32'd3);
        chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(INIT_W + 512));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done[1]), 32'd0);
        for (int g = 0; g < N; g++) begin
            ksa_model(key[g], kb_of(g), exp_s);
            for (int k = 0; k < 256; k++)
                if (smem[g][k] !== exp_s[k])
                    chk($sformatf("%s_S%0d[%0d]", tag, g, k), 32'(smem[g][k]), 32'(exp_s[k]));
                else n_chk++;
        end
    endtask

    function automatic logic [31:0] outs(int g);
        return 32'({busy[g], done[g], mem_we[g], mem_addr[g], mem_wdata[g]});
    endfunction

    initial begin
        int nbad;
        bit found;
        rst_n   = 1'b0;
        preload = 1'b0;
        for (int g = 0; g < N; g++) begin
            start[g] = 1'b0;
            key[g]   = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < N; g++) chk($sformatf("reset_outs%0d", g), outs(g), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outs", outs(1), 32'd0);

        // Directed key: first two swap iterations are known by hand.
        key[0] = 64'h5A;
        key[1] = 64'h010203;
        key[2] = 64'h0102030405;
        run_sched("k010203");
        if (INIT_W > 0) begin
            nbad = 0;
            for (int k = 0; k < INIT_W && k < wa_q.size(); k++)
                if (wa_q[k] != 8'(k) || wd_q[k] != 8'(k)) nbad++;
            chk("init_writes", 32'(nbad), 32'd0);
        end
        if (wa_q.size() >= INIT_W + 4) begin
            chk("w0_addr", 32'(wa_q[INIT_W+0]), 32'd0);
            chk("w0_data", 32'(wd_q[INIT_W+0]), 32'd1);
            chk("w1_addr", 32'(wa_q[INIT_W+1]), 32'd1);
            chk("w1_data", 32'(wd_q[INIT_W+1]), 32'd0);
            chk("w2_addr", 32'(wa_q[INIT_W+2]), 32'd1);
            chk("w2_data", 32'(wd_q[INIT_W+2]), 32'd3);
            chk("w3_addr", 32'(wa_q[INIT_W+3]), 32'd3);
            chk("w3_data", 32'(wd_q[INIT_W+3]), 32'd0);
        end else chk("w_present", 32'(wa_q.size()), 32'(INIT_W + 4));

        // i==j on the first iteration: both writes hit address 0 with 0.
        key[1] = 64'h000000;
        run_sched("k000000");
        if (wa_q.size() >= INIT_W + 2) begin
            chk("eq_w0", 32'({wa_q[INIT_W+0], wd_q[INIT_W+0]}), 32'd0);
            chk("eq_w1", 32'({wa_q[INIT_W+1], wd_q[INIT_W+1]}), 32'd0);
        end else chk("eq_present", 32'(wa_q.size()), 32'(INIT_W + 2));

        for (int r = 0; r < 3; r++) begin
            for (int g = 0; g < N; g++) key[g] = {$urandom, $urandom};
            run_sched($sformatf("rand%0d", r));
        end

        // start held high: DONE must be followed by an IDLE cycle before busy returns.
        for (int g = 0; g < N; g++) start[g] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < LAT_MAX && !found; c++) begin
            @(negedge clk);
            if (done[1]) found = 1'b1;
        end
        chk("held_done_seen", 32'(found), 32'd1);
        @(negedge clk);
        chk("held_idle_gap", 32'({busy[1], done[1]}), 32'd0);
        @(negedge clk);
        chk("held_restart", 32'(busy[1]), 32'd1);
        for (int g = 0; g < N; g++) start[g] = 1'b0;

        // Async reset in the middle of a schedule.
        pulse_preload();
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int g = 0; g < N; g++) start[g] = 1'b1;
        @(negedge clk);
        for (int g = 0; g < N; g++) start[g] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
`ifdef RC4_INIT_PHASE_EN
            if (mem_we[1] && mem_addr[1] == 8'd100) found = 1'b1;
`else
            if (c == 100) found = 1'b1;
`endif
            if (!found) @(negedge clk);
        end
        chk("rst_mid_reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", outs(1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nbad = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_we[1] || busy[1]) nbad++;
        end
        chk("rst_no_activity", 32'(nbad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
